// File: rtl/bram_portb_arbiter.sv
// rtl/bram_portb_arbiter.sv - round-robin sharing of BRAM port B between two requesters
//
// Purpose: grants one of two requesters per cycle onto the single port B of the
// transmit handshake BRAM, registers the port-B pins, tags in-flight reads and
// steers returned data back to the requester that issued the read.
//
// Ports:
//   clk_6144mhz          system clock, all logic on rising edge
//   rst                  asynchronous active-high reset
//   reqN_valid           requester N access request, held until accepted
//   reqN_we              1 = write, 0 = read
//   reqN_addr/wdata      access address / write data
//   reqN_ready           access accepted this cycle (combinational grant)
//   reqN_rvalid          one-cycle pulse, reqN_rdata holds the read result
//   reqN_rdata           read data for requester N (holds between pulses)
//   bram_doutb           BRAM port-B read data
//   bram_web/addrb/dinb  registered BRAM port-B write enable / address / write data
module bram_portb_arbiter #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 9,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_6144mhz,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic              bram_web,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dinb
);

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Read tag pipe: stage k is visible k+1 cycles after the read was accepted,
  // so the last stage lines up with the cycle bram_doutb carries the result.
  logic [READ_LATENCY:0] pipe_valid;
  logic [READ_LATENCY:0] pipe_id;

  // On conflict the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant) grant0 = 1'b1;
      else            grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = req0_valid & grant0;
  assign req1_ready = req1_valid & grant1;
  assign accept     = req0_ready | req1_ready;
  assign sel_we     = grant1 ? req1_we    : req0_we;
  assign sel_addr   = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata  = grant1 ? req1_wdata : req0_wdata;

  // Port-B pins; address and data hold while idle, only the write enable drops.
  always_ff @(posedge clk_6144mhz or posedge rst) begin
    if (rst) begin
      bram_web   <= 1'b0;
      bram_addrb <= '0;
      bram_dinb  <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      bram_web   <= sel_we;
      bram_addrb <= sel_addr;
      bram_dinb  <= sel_wdata;
      last_grant <= grant1;
    end else begin
      bram_web   <= 1'b0;
    end
  end

  always_ff @(posedge clk_6144mhz or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid[0] <= accept & ~sel_we;
      pipe_id[0]    <= grant1;
      pipe_valid[READ_LATENCY:1] <= pipe_valid[READ_LATENCY-1:0];
      pipe_id[READ_LATENCY:1]    <= pipe_id[READ_LATENCY-1:0];
    end
  end

  // Capture the returned word for the tagged requester; the pulse and the data
  // become visible together on the following cycle.
  always_ff @(posedge clk_6144mhz or posedge rst) begin
    if (rst) begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      req0_rvalid <= pipe_valid[READ_LATENCY] & ~pipe_id[READ_LATENCY];
      req1_rvalid <= pipe_valid[READ_LATENCY] &  pipe_id[READ_LATENCY];
      if (pipe_valid[READ_LATENCY] && !pipe_id[READ_LATENCY]) req0_rdata <= bram_doutb;
      if (pipe_valid[READ_LATENCY] &&  pipe_id[READ_LATENCY]) req1_rdata <= bram_doutb;
    end
  end

endmodule
